// File: rtl/cache_ctrl_if.sv
`default_nettype none
// =============================================================================
// cache_ctrl_if : CPU, cache-array and memory buses of the cache controller
// Rev 1.0
// =============================================================================
interface cache_ctrl_if #(
  parameter int ADDR_BITS = 32,
  parameter int TAG_BITS  = 23
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [31:0]          cpu_din;
  logic [31:0]          cpu_dout;
  logic                 cpu_ready;

  logic [ADDR_BITS-1:0] cache_addr;
  logic                 cache_load;
  logic                 cache_edit;
  logic                 cache_store;
  logic [31:0]          cache_din;
  logic                 cache_hit;
  logic                 cache_valid;
  logic                 cache_dirty;
  logic [TAG_BITS-1:0]  cache_tag;
  logic [31:0]          cache_dout;

  logic                 mem_cs;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_dout;
  logic [31:0]          mem_din;
  logic                 mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ready,
    output cache_addr, cache_load, cache_edit, cache_store, cache_din,
    input  cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    output mem_cs, mem_we, mem_addr, mem_dout,
    input  mem_din, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ready,
    input  cache_addr, cache_load, cache_edit, cache_store, cache_din,
    output cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    input  mem_cs, mem_we, mem_addr, mem_dout,
    output mem_din, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// =============================================================================
// cache_ctrl : miss-handling FSM for a 2-way write-back cache (write-back, refill)
// Rev 1.0
// =============================================================================
module cache_ctrl #(
  parameter int ADDR_BITS  = 32,
  parameter int TAG_BITS   = 23,
  parameter int LINE_WORDS = 4
) (
  input wire           clk,
  input wire           rst_n,
  cache_ctrl_if.master bus
);

  localparam int WB     = $clog2(LINE_WORDS);
  localparam int IDX_LO = WB + 2;
  localparam int IDX_HI = ADDR_BITS - TAG_BITS - 1;
  localparam logic [WB-1:0] C_LAST = WB'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_BACK_RD = 3'd2,
    S_BACK_WR = 3'd3,
    S_FILL    = 3'd4,
    S_LOOKUP  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [WB-1:0]        cnt_q, cnt_d;
  logic [TAG_BITS-1:0]  vtag_q, vtag_d;
  logic [ADDR_BITS-1:0] wb_addr, fill_addr;

  // Write-back walks the victim line; refill walks the requested line.
  assign wb_addr   = {vtag_q, bus.cpu_addr[IDX_HI:IDX_LO], cnt_q, 2'b00};
  assign fill_addr = {bus.cpu_addr[ADDR_BITS-1:IDX_LO], cnt_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vtag_q  <= vtag_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    vtag_d          = vtag_q;
    bus.cpu_dout    = '0;
    bus.cpu_ready   = 1'b0;
    bus.cache_addr  = '0;
    bus.cache_load  = 1'b0;
    bus.cache_edit  = 1'b0;
    bus.cache_store = 1'b0;
    bus.cache_din   = '0;
    bus.mem_cs      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_dout    = '0;
    // Outputs are forced low for the whole reset window, not just after the edge.
    if (rst_n) begin
      case (state_q)
        S_IDLE, S_LOOKUP: begin
          if (bus.cpu_req || state_q == S_LOOKUP) begin
            bus.cache_addr = bus.cpu_addr;
            bus.cache_load = ~bus.cpu_we;
            bus.cache_edit = bus.cpu_we;
            bus.cache_din  = bus.cpu_din;
            state_d        = S_CHECK;
          end
        end
        S_CHECK: begin
          if (bus.cache_hit) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_dout  = bus.cache_dout;
            state_d       = S_IDLE;
          end else begin
            vtag_d  = bus.cache_tag;
            cnt_d   = '0;
            state_d = (bus.cache_valid && bus.cache_dirty) ? S_BACK_RD : S_FILL;
          end
        end
        S_BACK_RD: begin
          bus.cache_addr = wb_addr;
          state_d        = S_BACK_WR;
        end
        S_BACK_WR: begin
          bus.cache_addr = wb_addr;
          bus.mem_cs     = 1'b1;
          bus.mem_we     = 1'b1;
          bus.mem_addr   = wb_addr;
          bus.mem_dout   = bus.cache_dout;
          if (bus.mem_ack) begin
            cnt_d   = cnt_q + WB'(1);
            state_d = (cnt_q == C_LAST) ? S_FILL : S_BACK_RD;
          end
        end
        S_FILL: begin
          bus.mem_cs      = 1'b1;
          bus.mem_addr    = fill_addr;
          bus.cache_addr  = fill_addr;
          bus.cache_din   = bus.mem_din;
          bus.cache_store = bus.mem_ack;
          if (bus.mem_ack) begin
            cnt_d   = cnt_q + WB'(1);
            state_d = (cnt_q == C_LAST) ? S_LOOKUP : S_FILL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// =============================================================================
// tb_cache_ctrl : directed bench with a 2-way array model and a memory responder
// Rev 1.0
// =============================================================================
module tb_cache_ctrl;
  localparam int AB = 32;
  localparam int TB = 23;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_ctrl_if #(.ADDR_BITS(AB), .TAG_BITS(TB)) bus ();

  cache_ctrl #(.ADDR_BITS(AB), .TAG_BITS(TB), .LINE_WORDS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ack_delay = 0;
  logic unstable = 1'b0;
  logic arr_clr;
  int store_cnt;
  logic excl_err;

  logic [31:0] mem [1024];
  logic [31:0] log_addr [$];
  logic        log_we   [$];
  logic [31:0] log_dat  [$];

  // ---------------- 2-way, 32-set, 4-word array model ----------------
  logic [TB-1:0] a_tag [32][2];
  logic          a_val [32][2];
  logic          a_dty [32][2];
  logic [31:0]   a_dat [32][2][4];
  logic          a_lru [32];

  wire [4:0]    w_idx = bus.cache_addr[8:4];
  wire [TB-1:0] w_tag = bus.cache_addr[31:9];
  wire [1:0]    w_wd  = bus.cache_addr[3:2];
  wire w_h0  = a_val[w_idx][0] && (a_tag[w_idx][0] == w_tag);
  wire w_h1  = a_val[w_idx][1] && (a_tag[w_idx][1] == w_tag);
  wire w_hit = w_h0 || w_h1;
  wire w_hw  = w_h1;
  wire w_vic = a_lru[w_idx];

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int s = 0; s < 32; s++) begin
        a_val[s][0] <= 1'b0; a_val[s][1] <= 1'b0;
        a_dty[s][0] <= 1'b0; a_dty[s][1] <= 1'b0;
        a_lru[s]    <= 1'b0;
      end
      bus.cache_hit <= 1'b0;
      store_cnt     <= 0;
      excl_err      <= 1'b0;
    end else begin
      bus.cache_hit   <= w_hit;
      bus.cache_valid <= a_val[w_idx][w_vic];
      bus.cache_dirty <= a_dty[w_idx][w_vic];
      bus.cache_tag   <= a_tag[w_idx][w_vic];
      bus.cache_dout  <= w_hit ? a_dat[w_idx][w_hw][w_wd] : a_dat[w_idx][w_vic][w_wd];
      if (bus.cache_load && w_hit) a_lru[w_idx] <= ~w_hw;
      if (bus.cache_edit && w_hit) begin
        a_dat[w_idx][w_hw][w_wd] <= bus.cache_din;
        a_dty[w_idx][w_hw]       <= 1'b1;
        a_lru[w_idx]             <= ~w_hw;
      end
      if (bus.cache_store) begin
        a_dat[w_idx][w_vic][w_wd] <= bus.cache_din;
        a_tag[w_idx][w_vic]       <= w_tag;
        a_val[w_idx][w_vic]       <= 1'b1;
        a_dty[w_idx][w_vic]       <= 1'b0;
        store_cnt                 <= store_cnt + 1;
      end
      if ($countones({bus.cache_load, bus.cache_edit, bus.cache_store}) > 1) excl_err <= 1'b1;
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    int wc;
    logic [31:0] ra, rd;
    logic rw;
    bus.mem_ack = 1'b0; bus.mem_din = '0;
    wc = 0; ra = '0; rd = '0; rw = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
    forever begin
      @(negedge clk);
      if (!rst_n || bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wc = 0;
      end else if (bus.mem_cs) begin
        if (wc == 0) begin
          ra = bus.mem_addr; rw = bus.mem_we; rd = bus.mem_dout;
        end else if (bus.mem_addr !== ra || bus.mem_we !== rw || (rw && bus.mem_dout !== rd)) begin
          unstable = 1'b1;
        end
        if (wc >= ack_delay) begin
          bus.mem_ack = 1'b1;
          if (rw) mem[ra[11:2]] = rd;
          else    bus.mem_din = mem[ra[11:2]];
          log_addr.push_back(ra);
          log_we.push_back(rw);
          log_dat.push_back(rw ? rd : mem[ra[11:2]]);
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_we.delete(); log_dat.delete();
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] din,
                        output int lat, output logic [31:0] dout, output logic ok);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = din;
    lat = 0; ok = 1'b0; dout = '0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        lat = i; dout = bus.cpu_dout; ok = 1'b1;
        break;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int lat, sc0;
    logic ok, found;
    logic [31:0] wexp [4];

    // Reset with a request already pending: nothing may leak out.
    rst_n = 1'b0; arr_clr = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h104; bus.cpu_din = '0;
    repeat (2) @(negedge clk);
    chk("rst_cache_addr", bus.cache_addr, 32'h0);
    chk("rst_cache_load", 32'(bus.cache_load), 32'h0);
    chk("rst_mem_cs",     32'(bus.mem_cs), 32'h0);
    chk("rst_cpu_ready",  32'(bus.cpu_ready), 32'h0);
    bus.cpu_req = 1'b0; arr_clr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1. clean read miss
    clear_log();
    cpu_op(1'b0, 32'h104, '0, lat, d, ok);
    chk("t1_done", 32'(ok), 32'h1);
    chk("t1_dout", d, 32'hC0DE_0104);
    chk("t1_nmem", 32'(log_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      chk($sformatf("t1_addr%0d", k), log_addr[k], 32'h100 + 32'(4 * k));
      chk($sformatf("t1_we%0d", k), 32'(log_we[k]), 32'h0);
    end

    // 2. load hit
    clear_log();
    cpu_op(1'b0, 32'h104, '0, lat, d, ok);
    chk("t2_lat",  32'(lat), 32'd1);
    chk("t2_dout", d, 32'hC0DE_0104);
    chk("t2_nmem", 32'(log_addr.size()), 32'd0);

    // 3. store hit, fill other way, then dirty eviction
    cpu_op(1'b1, 32'h104, 32'hDEAD_BEEF, lat, d, ok);
    chk("t3_st_lat",  32'(lat), 32'd1);
    chk("t3_st_nmem", 32'(log_addr.size()), 32'd0);
    cpu_op(1'b0, 32'h304, '0, lat, d, ok);
    chk("t3_304_dout", d, 32'hC0DE_0304);
    chk("t3_304_nmem", 32'(log_addr.size()), 32'd4);
    clear_log();
    cpu_op(1'b0, 32'h504, '0, lat, d, ok);
    chk("t3_504_dout", d, 32'hC0DE_0504);
    chk("t3_504_nmem", 32'(log_addr.size()), 32'd8);
    wexp = '{32'hC0DE_0100, 32'hDEAD_BEEF, 32'hC0DE_0108, 32'hC0DE_010C};
    for (int k = 0; k < 8 && k < log_addr.size(); k++) begin
      if (k < 4) begin
        chk($sformatf("t3_wb_addr%0d", k), log_addr[k], 32'h100 + 32'(4 * k));
        chk($sformatf("t3_wb_we%0d", k), 32'(log_we[k]), 32'h1);
        chk($sformatf("t3_wb_dat%0d", k), log_dat[k], wexp[k]);
      end else begin
        chk($sformatf("t3_rf_addr%0d", k), log_addr[k], 32'h500 + 32'(4 * (k - 4)));
        chk($sformatf("t3_rf_we%0d", k), 32'(log_we[k]), 32'h0);
      end
    end

    // 4. refill with slow acknowledge
    ack_delay = 5; unstable = 1'b0; sc0 = store_cnt;
    clear_log();
    cpu_op(1'b0, 32'h904, '0, lat, d, ok);
    chk("t4_dout",     d, 32'hC0DE_0904);
    chk("t4_stores",   32'(store_cnt - sc0), 32'd4);
    chk("t4_unstable", 32'(unstable), 32'h0);
    chk("t4_nmem",     32'(log_addr.size()), 32'd4);

    // 5. reset in the middle of a write-back
    cpu_op(1'b1, 32'h904, 32'hCAFE_F00D, lat, d, ok);
    chk("t5_st_lat", 32'(lat), 32'd1);
    cpu_op(1'b0, 32'h504, '0, lat, d, ok);
    chk("t5_ld_lat", 32'(lat), 32'd1);
    clear_log();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hB04;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_cs && bus.mem_we && bus.mem_addr == 32'h908) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reach_word2", 32'(found), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_cs",     32'(bus.mem_cs), 32'h0);
    chk("t5_mem_we",     32'(bus.mem_we), 32'h0);
    chk("t5_mem_addr",   bus.mem_addr, 32'h0);
    chk("t5_cache_addr", bus.cache_addr, 32'h0);
    chk("t5_nmem",       32'(log_addr.size()), 32'd2);
    if (log_dat.size() > 1) chk("t5_wb_dat1", log_dat[1], 32'hCAFE_F00D);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ack_delay = 0;
    clear_log();
    cpu_op(1'b0, 32'h104, '0, lat, d, ok);
    chk("t5_post_dout", d, 32'hDEAD_BEEF);
    chk("t5_post_nmem", 32'(log_addr.size()), 32'd8);
    if (log_addr.size() == 8) begin
      chk("t5_post_first", log_addr[0], 32'h900);
      chk("t5_post_we0",   32'(log_we[0]), 32'h1);
      chk("t5_post_fill",  log_addr[4], 32'h100);
    end

    chk("exclusive_strobes", 32'(excl_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
